// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared FSM states and array defaults for the correlation scan controller
package corr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DISP_DEFAULT     = 21;
    localparam int CORR_LAT_DEFAULT = 2;

endpackage

// File: rtl/corr_scan_ctrl.sv
// rtl/corr_scan_ctrl.sv - sequences one scanline through the correlation array and tags valid results
module corr_scan_ctrl
    import corr_pkg::*;
#(
    parameter int LINE_W   = 320,
    parameter int DISP     = DISP_DEFAULT,
    parameter int CORR_LAT = CORR_LAT_DEFAULT,
    parameter int CW       = $clog2(LINE_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    input  logic          line_start,
    output logic          pix_ready,
    output logic          wen,
    output logic          flush_sel,
    output logic          out_valid,
    output logic [CW-1:0] out_col,
    output logic          line_done,
    output logic          err
);

    localparam int NW = $clog2(LINE_W + CORR_LAT + 1);

    state_e          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [CW-1:0]   col_q, col_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   out_col_q, out_col_d;
    logic            line_done_q, line_done_d;
    logic            err_q, err_d;
    logic            accept;
    logic [NW-1:0]   idx;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        col_d       = col_q;
        out_valid_d = 1'b0;
        out_col_d   = out_col_q;
        line_done_d = 1'b0;
        err_d       = err_q;
        wen         = 1'b0;
        flush_sel   = 1'b0;
        idx         = n_q;
        pix_ready   = (state_q != DRAIN);
        accept      = pix_valid & pix_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (line_start) begin
                        // the line-start pixel is wen index 0, so the counter resumes at 1
                        wen     = 1'b1;
                        idx     = '0;
                        n_d     = NW'(1);
                        col_d   = CW'(1);
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    wen   = 1'b1;
                    n_d   = n_q + 1'b1;
                    err_d = err_q | line_start;
                    if (col_q == CW'(LINE_W - 1)) begin
                        col_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                wen       = 1'b1;
                flush_sel = 1'b1;
                n_d       = n_q + 1'b1;
                if (n_q == NW'(LINE_W + CORR_LAT - 1)) begin
                    state_d     = IDLE;
                    line_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // results emerge CORR_LAT pulses late and only once all DISP stages hold real pixels
        if (wen && idx >= NW'(CORR_LAT + DISP - 1)) begin
            out_valid_d = 1'b1;
            out_col_d   = CW'(idx - NW'(CORR_LAT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            line_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            line_done_q <= line_done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign line_done = line_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_corr_scan_ctrl.sv
// tb/tb_corr_scan_ctrl.sv - self-checking bench for corr_scan_ctrl (default size and minimal 22-pixel line)
module tb_corr_scan_ctrl;

    localparam int LW0 = 320;
    localparam int LW1 = 22;
    localparam int DSP = 21;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, pv0 = 1'b0, ls0 = 1'b0;
    logic       ready0, wen0, flush0, ov0, done0, err0;
    logic [8:0] col0;
    logic       rst1 = 1'b1, pv1 = 1'b0, ls1 = 1'b0;
    logic       ready1, wen1, flush1, ov1, done1, err1;
    logic [4:0] col1;

    corr_scan_ctrl #(.LINE_W(LW0), .DISP(DSP), .CORR_LAT(LAT)) dut0 (
        .clk(clk), .rst(rst0), .pix_valid(pv0), .line_start(ls0), .pix_ready(ready0),
        .wen(wen0), .flush_sel(flush0), .out_valid(ov0), .out_col(col0),
        .line_done(done0), .err(err0));

    corr_scan_ctrl #(.LINE_W(LW1), .DISP(DSP), .CORR_LAT(LAT)) dut1 (
        .clk(clk), .rst(rst1), .pix_valid(pv1), .line_start(ls1), .pix_ready(ready1),
        .wen(wen1), .flush_sel(flush1), .out_valid(ov1), .out_col(col1),
        .line_done(done1), .err(err1));

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];
    int wen_cnt0 = 0, done_cnt0 = 0, fl_cnt0 = 0;
    int wen_cnt1 = 0, done_cnt1 = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wen0) wen_cnt0++;
        if (flush0) begin
            fl_cnt0++;
            chk("drain_not_ready", int'(ready0), 0);
        end
        if (done0) done_cnt0++;
        if (ov0) begin
            if (q0.size() == 0) chk("unexpected_out_valid0", int'(col0), -1);
            else chk("out_col0", int'(col0), q0.pop_front());
        end
        if (wen1) wen_cnt1++;
        if (done1) done_cnt1++;
        if (ov1) begin
            if (q1.size() == 0) chk("unexpected_out_valid1", int'(col1), -1);
            else chk("out_col1", int'(col1), q1.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step0(input logic pv, input logic ls);
        pv0 = pv;
        ls0 = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic pv, input logic ls);
        pv1 = pv;
        ls1 = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic run_line0(input int stall, input int exp_err);
        wen_cnt0 = 0;
        done_cnt0 = 0;
        fl_cnt0 = 0;
        for (int c = DSP - 1; c < LW0; c++) q0.push_back(c);
        step0(1'b1, 1'b1);
        for (int c = 1; c < LW0; c++) begin
            while ($urandom_range(1, 100) <= stall) step0(1'b0, 1'b0);
            step0(1'b1, 1'b0);
        end
        // pixels offered during drain must be ignored without error
        step0(1'b1, 1'b0);
        step0(1'b1, 1'b0);
        for (int i = 0; i < 20 && done_cnt0 == 0; i++) step0(1'b0, 1'b0);
        chk("line_done_count", done_cnt0, 1);
        chk("wen_count", wen_cnt0, LW0 + LAT);
        chk("flush_count", fl_cnt0, LAT);
        chk("results_left", q0.size(), 0);
        chk("err_after_line", int'(err0), exp_err);
    endtask

    typedef struct {
        logic pv;
        logic ls;
        logic exp_ready;
        logic exp_wen;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{pv: 1'b0, ls: 1'b0, exp_ready: 1'b1, exp_wen: 1'b0};
        tbl[1] = '{pv: 1'b1, ls: 1'b0, exp_ready: 1'b1, exp_wen: 1'b0};
        tbl[2] = '{pv: 1'b0, ls: 1'b1, exp_ready: 1'b1, exp_wen: 1'b0};
        tbl[3] = '{pv: 1'b1, ls: 1'b1, exp_ready: 1'b1, exp_wen: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        // IDLE decode while rst keeps the state pinned
        for (int i = 0; i < 4; i++) begin
            pv0 = tbl[i].pv;
            ls0 = tbl[i].ls;
            #3;
            chk($sformatf("tbl%0d_ready", i), int'(ready0), int'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_wen", i), int'(wen0), int'(tbl[i].exp_wen));
            chk($sformatf("tbl%0d_flush", i), int'(flush0), 0);
            @(posedge clk);
            #1;
        end
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_out_col", int'(col0), 0);
        chk("rst_line_done", int'(done0), 0);
        chk("rst_err", int'(err0), 0);
        pv0 = 1'b0;
        ls0 = 1'b0;
        rst0 = 1'b0;
        step0(1'b0, 1'b0);

        run_line0(0, 0);
        run_line0(50, 0);

        wen_cnt0 = 0;
        step0(1'b1, 1'b0);
        chk("idle_stray_no_wen", wen_cnt0, 0);
        chk("idle_stray_err", int'(err0), 1);
        step0(1'b0, 1'b0);
        run_line0(0, 1);

        for (int c = DSP - 1; c < LW0; c++) q0.push_back(c);
        done_cnt0 = 0;
        step0(1'b1, 1'b1);
        for (int c = 1; c < 150; c++) step0(1'b1, 1'b0);
        rst0 = 1'b1;
        step0(1'b1, 1'b0);
        q0.delete();
        chk("midline_rst_out_valid", int'(ov0), 0);
        chk("midline_rst_out_col", int'(col0), 0);
        chk("midline_rst_line_done", int'(done0), 0);
        chk("midline_rst_err", int'(err0), 0);
        chk("midline_rst_flush", int'(flush0), 0);
        chk("midline_rst_wen", int'(wen0), 0);
        rst0 = 1'b0;
        for (int i = 0; i < 5; i++) step0(1'b0, 1'b0);
        chk("midline_rst_no_done", done_cnt0, 0);
        run_line0(0, 0);

        rst1 = 1'b0;
        step1(1'b0, 1'b0);
        wen_cnt1 = 0;
        // two minimal lines, the second starting in the line_done cycle of the first
        for (int l = 0; l < 2; l++) begin
            q1.push_back(DSP - 1);
            q1.push_back(DSP);
            step1(1'b1, 1'b1);
            for (int c = 1; c < LW1; c++) step1(1'b1, 1'b0);
            step1(1'b0, 1'b0);
            step1(1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step1(1'b0, 1'b0);
        chk("small_line_done_count", done_cnt1, 2);
        chk("small_wen_count", wen_cnt1, 2 * (LW1 + LAT));
        chk("small_results_left", q1.size(), 0);
        chk("small_err", int'(err1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/corr_scan_ctrl.md
CORR_SCAN_CTRL -- requirements
Module: corr_scan_ctrl

Interface
REQ-001 Parameter LINE_W, default 320: pixels per scanline, at least DISP+1.
REQ-002 Parameter DISP, default 21: number of correlation stages (disparities) in the sequenced array.
REQ-003 Parameter CORR_LAT, default 2: wen pulses from a pixel entering the array until its correlation result is registered at the array output.
REQ-004 Parameter CW = clog2(LINE_W): column-index width.
REQ-005 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port pix_valid, input, 1: a left/right pixel pair is offered.
REQ-009 Port line_start, input, 1: qualifies the offered pair as column 0 of a line.
REQ-010 Port pix_ready, output, 1: controller accepts the pair this cycle.
REQ-011 Port wen, output, 1: advance enable for the shift-register/correlation array.
REQ-012 Port flush_sel, output, 1: array data mux selects zero pixels; high only during drain.
REQ-013 Port out_valid, output, 1: array correlation outputs hold a valid result this cycle.
REQ-014 Port out_col, output, CW: column of the valid result.
REQ-015 Port line_done, output, 1: one-cycle pulse when a line is fully drained.
REQ-016 Port err, output, 1: sticky protocol-error flag.

Function
REQ-017 The controller SHALL use FSM states IDLE, RUN and DRAIN.
- IDLE -> RUN on accepted pix_valid&line_start.
- RUN -> DRAIN on accepting column LINE_W-1.
- DRAIN -> IDLE after CORR_LAT drain pulses.
REQ-018 Acceptance is pix_valid&pix_ready. pix_ready SHALL be 1 in IDLE and RUN and 0 in DRAIN.
REQ-019 wen SHALL be combinational: (accept & state in {IDLE with line_start, RUN}) | (state==DRAIN). No other cycle SHALL assert wen.
REQ-020 A wen counter n SHALL clear on line start and increment per wen. Total wen per line is exactly LINE_W+CORR_LAT.
REQ-021 Column counter: increments per accepted pixel; used for the RUN->DRAIN transition.
REQ-022 out_valid SHALL be registered: high in the cycle after the wen pulse whose index n >= CORR_LAT+DISP-1, with out_col = n-CORR_LAT.
- Yields LINE_W-DISP+1 results, columns DISP-1..LINE_W-1, strictly increasing by 1.
REQ-023 Stall: pix_valid low in RUN SHALL hold all counters and keep wen low. Results are not lost and no duplicates are produced.
REQ-024 DRAIN SHALL assert flush_sel and wen for exactly CORR_LAT consecutive cycles. line_done SHALL pulse in the cycle after the last drain wen, together with the final out_valid.
REQ-025 Pixels in IDLE without line_start SHALL be consumed, produce no wen, and set err.
REQ-026 line_start accepted in RUN SHALL be treated as an ordinary pixel and set err.
REQ-027 pix_valid in DRAIN SHALL be ignored: not ready, and no error.
REQ-028 err SHALL clear only on rst.

Reset
REQ-029 rst SHALL force state IDLE, both counters 0, and out_valid, out_col, line_done, err, flush_sel = 0.
- wen then follows REQ-019.
REQ-030 rst asserted mid-line or mid-drain SHALL abandon the line: no line_done and no further out_valid for it.
REQ-031 rst SHALL override a simultaneous accept.

Structure
REQ-032 Package corr_pkg SHALL hold the FSM state enum and the default DISP/CORR_LAT constants shared with the correlation array.
REQ-033 The block SHALL be a single module with no sub-module. Counters and FSM are inline.

Verification
REQ-034 Full line, defaults, pix_valid always 1 -> 322 wen pulses, 300 out_valid with out_col 20..319, line_done once, err=0.
REQ-035 Random stalls (50% pix_valid) over one line -> the same 300 results in order, with wen count 322.
REQ-036 Pixel without line_start in IDLE -> no wen, err=1 sticky; a following proper line runs normally.
REQ-037 rst at column 150 -> all outputs 0 next cycle, no line_done; a new line starts cleanly from column 0.
REQ-038 LINE_W=22, DISP=21 -> exactly 2 results (cols 20, 21). Back-to-back line_start the cycle after line_done -> accepted, no err.
